// File: rtl/run_ctrl_fsm.sv
// run_ctrl_fsm: run/pause/reset sequencer with a bounded run-cycle
// counter, DONE state, minimum reset hold and optional auto-restart.
module run_ctrl_fsm #(
    parameter int CNT_W        = 8,
    parameter int RUN_LEN      = 10,
    parameter int RESET_CYCLES = 2,
    parameter bit AUTO_RESTART = 1'b0
) (
    input  logic             CLK,
    input  logic             S,
    input  logic [1:0]       I,
    output logic [1:0]       O,
    output logic [CNT_W-1:0] CNT,
    output logic             DONE_P
);

    localparam longint MAX_LEN = (longint'(1) << CNT_W) - 1;
    localparam int HOLD_W =
        (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RUN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(RUN_LEN);

    localparam logic [1:0] CMD_PAUSE = 2'b00;
    localparam logic [1:0] CMD_RUN   = 2'b01;
    localparam logic [1:0] CMD_RESET = 2'b10;

    // State codes double as the O output encoding.
    typedef enum logic [1:0] {
        ST_RESET = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    if (RUN_LEN < 1 || longint'(RUN_LEN) > MAX_LEN) begin : g_bad_run_len
        $error("run_ctrl_fsm: RUN_LEN out of range 1..2^CNT_W-1");
    end
    if (RESET_CYCLES < 1) begin : g_bad_reset_cycles
        $error("run_ctrl_fsm: RESET_CYCLES must be >= 1");
    end

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              done_p_q, done_p_d;

    // State, counter, hold and pulse registers; S wins over any command.
    always_ff @(posedge CLK) begin
        if (!S) begin
            state_q  <= ST_RESET;
            cnt_q    <= '0;
            hold_q   <= HOLD_INIT;
            done_p_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hold_q   <= hold_d;
            done_p_q <= done_p_d;
        end
    end

    // Next-state, counter and hold logic; a reset command overrides all.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        done_p_d = 1'b0;
        if (I == CMD_RESET) begin
            state_d = ST_RESET;
            cnt_d   = '0;
            hold_d  = HOLD_INIT;
        end else begin
            unique case (state_q)
                ST_RESET: begin
                    cnt_d = '0;
                    if (hold_q != '0) begin
                        hold_d = hold_q - 1'b1;
                    end else if (I == CMD_RUN) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (I == CMD_RUN) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d    = CNT_TERM;
                        state_d  = ST_DONE;
                        done_p_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (I == CMD_PAUSE) begin
                            state_d = ST_PAUSE;
                        end
                    end
                end
                ST_DONE: begin
                    if (AUTO_RESTART) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_RESET;
                    cnt_d   = '0;
                    hold_d  = HOLD_INIT;
                end
            endcase
        end
    end

    assign O      = state_q;
    assign CNT    = cnt_q;
    assign DONE_P = done_p_q;

endmodule

// File: tb/tb_run_ctrl_fsm.sv
// tb_run_ctrl_fsm: directed stimulus for a default instance and an
// auto-restart RUN_LEN=1 instance, checked against a behavioural model.
module tb_run_ctrl_fsm;

    logic       CLK;
    logic       S;
    logic [1:0] I;
    logic [1:0] o_a, o_b;
    logic [7:0] cnt_a, cnt_b;
    logic       dp_a, dp_b;

    int checks = 0;
    int errors = 0;

    run_ctrl_fsm dut_a (
        .CLK(CLK), .S(S), .I(I), .O(o_a), .CNT(cnt_a), .DONE_P(dp_a)
    );

    run_ctrl_fsm #(
        .CNT_W(8), .RUN_LEN(1), .RESET_CYCLES(2), .AUTO_RESTART(1'b1)
    ) dut_b (
        .CLK(CLK), .S(S), .I(I), .O(o_b), .CNT(cnt_b), .DONE_P(dp_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Model: phase 0 reset, 1 run, 2 pause, 3 done (same as O codes).
    int  m_len[2] = '{10, 1};
    bit  m_ar[2]  = '{1'b0, 1'b1};
    int  m_rc     = 2;
    int  m_st[2];
    int  m_cnt[2];
    int  m_rem[2];
    bit  m_dp[2];
    bit  m_valid = 1'b0;

    task automatic model_step(input int k);
        m_dp[k] = 1'b0;
        if (!S || I == 2'b10) begin
            m_st[k]  = 0;
            m_cnt[k] = 0;
            m_rem[k] = m_rc - 1;
        end else if (m_st[k] == 0) begin
            if (m_rem[k] > 0) m_rem[k] = m_rem[k] - 1;
            else m_st[k] = (I == 2'b01) ? 1 : 2;
        end else if (m_st[k] == 2) begin
            if (I == 2'b01) m_st[k] = 1;
        end else if (m_st[k] == 1) begin
            m_cnt[k] = m_cnt[k] + 1;
            if (m_cnt[k] == m_len[k]) begin
                m_st[k] = 3;
                m_dp[k] = 1'b1;
            end else if (I == 2'b00) begin
                m_st[k] = 2;
            end
        end else if (m_ar[k]) begin
            m_st[k]  = 1;
            m_cnt[k] = 0;
        end
    endtask

    task automatic cmp(input string nm, input int got, input int exp);
        checks = checks + 1;
        if (got != exp) begin
            errors = errors + 1;
            $display("FAIL %s got %0d expected %0d at %0t", nm, got, exp,
                     $time);
        end
    endtask

    task automatic model_cmp();
        cmp("a_O", int'(o_a), m_st[0]);
        cmp("a_CNT", int'(cnt_a), m_cnt[0]);
        cmp("a_DONE_P", int'(dp_a), int'(m_dp[0]));
        cmp("b_O", int'(o_b), m_st[1]);
        cmp("b_CNT", int'(cnt_b), m_cnt[1]);
        cmp("b_DONE_P", int'(dp_b), int'(m_dp[1]));
    endtask

    // One clock edge: apply inputs, advance model, check every output.
    task automatic drive(input logic s, input logic [1:0] i);
        @(negedge CLK);
        S = s;
        I = i;
        @(posedge CLK);
        model_step(0);
        model_step(1);
        if (!s) m_valid = 1'b1;
        #1;
        if (m_valid) model_cmp();
    endtask

    task automatic lit_a(input string nm, input int o, input int c,
                         input int d);
        cmp({nm, "_O"}, int'(o_a), o);
        cmp({nm, "_CNT"}, int'(cnt_a), c);
        cmp({nm, "_DP"}, int'(dp_a), d);
    endtask

    task automatic lit_b(input string nm, input int o, input int c,
                         input int d);
        cmp({nm, "_O"}, int'(o_b), o);
        cmp({nm, "_CNT"}, int'(cnt_b), c);
        cmp({nm, "_DP"}, int'(dp_b), d);
    endtask

    initial begin
        S = 1'b0;
        I = 2'b00;
        // reset and hold
        drive(1'b0, 2'b00);
        drive(1'b0, 2'b00);
        lit_a("rst", 0, 0, 0);
        drive(1'b1, 2'b00);
        lit_a("hold1", 0, 0, 0);
        drive(1'b1, 2'b00);
        lit_a("to_pause", 2, 0, 0);
        // run from pause, then pause
        drive(1'b1, 2'b01);
        lit_a("run0", 1, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            drive(1'b1, 2'b01);
            lit_a("run_k", 1, k, 0);
        end
        drive(1'b1, 2'b00);
        lit_a("pause4", 2, 4, 0);
        drive(1'b1, 2'b11);
        lit_a("pause_nop", 2, 4, 0);
        drive(1'b1, 2'b01);
        lit_a("resume", 1, 4, 0);
        drive(1'b1, 2'b01);
        lit_a("resume5", 1, 5, 0);
        drive(1'b1, 2'b11);
        lit_a("run_nop", 1, 6, 0);
        drive(1'b1, 2'b01);
        drive(1'b1, 2'b01);
        drive(1'b1, 2'b01);
        lit_a("cnt9", 1, 9, 0);
        // pause on the terminal edge still reaches DONE
        drive(1'b1, 2'b00);
        lit_a("term_pause", 3, 10, 1);
        drive(1'b1, 2'b00);
        lit_a("done_hold", 3, 10, 0);
        drive(1'b1, 2'b01);
        drive(1'b1, 2'b11);
        lit_a("done_stay", 3, 10, 0);
        drive(1'b1, 2'b10);
        lit_a("done_rst", 0, 0, 0);
        // continuous run to DONE
        drive(1'b1, 2'b01);
        lit_a("hold_run", 0, 0, 0);
        drive(1'b1, 2'b01);
        lit_a("run_entry", 1, 0, 0);
        for (int k = 1; k <= 9; k++) begin
            drive(1'b1, 2'b01);
            lit_a("run_seq", 1, k, 0);
        end
        drive(1'b1, 2'b01);
        lit_a("done10", 3, 10, 1);
        drive(1'b1, 2'b01);
        lit_a("done_p_once", 3, 10, 0);
        // reset command mid-run and hold restart
        drive(1'b1, 2'b10);
        drive(1'b1, 2'b01);
        drive(1'b1, 2'b01);
        drive(1'b1, 2'b01);
        drive(1'b1, 2'b01);
        drive(1'b1, 2'b01);
        lit_a("cnt3", 1, 3, 0);
        drive(1'b1, 2'b10);
        lit_a("mid_rst", 0, 0, 0);
        drive(1'b1, 2'b01);
        lit_a("hold_a", 0, 0, 0);
        drive(1'b1, 2'b10);
        lit_a("hold_reload", 0, 0, 0);
        drive(1'b1, 2'b01);
        lit_a("hold_b", 0, 0, 0);
        drive(1'b1, 2'b01);
        lit_a("hold_exit", 1, 0, 0);
        // auto-restart instance, RUN_LEN=1
        drive(1'b0, 2'b01);
        lit_b("b_rst", 0, 0, 0);
        drive(1'b1, 2'b01);
        drive(1'b1, 2'b01);
        lit_b("b_run0", 1, 0, 0);
        drive(1'b1, 2'b01);
        lit_b("b_done1", 3, 1, 1);
        drive(1'b1, 2'b01);
        lit_b("b_run1", 1, 0, 0);
        drive(1'b1, 2'b01);
        lit_b("b_done2", 3, 1, 1);
        drive(1'b0, 2'b01);
        lit_b("b_s_mid", 0, 0, 0);
        lit_a("a_s_mid", 0, 0, 0);
        drive(1'b1, 2'b11);
        drive(1'b1, 2'b11);
        lit_a("nop_exit", 2, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
